// File: rtl/f7_scan_ctrl.sv
// f7_scan_ctrl: walks a small combinational unit through all 2**N_IN input
// vectors and captures its 1-bit response per vector into a truth table.
// One start pulse in IDLE launches a full scan; busy is high while scanning
// and done pulses for one cycle when the table is complete.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   start       scan request, honoured only in IDLE
//   res_i       unit response, sampled once per vector
//   vec_o       vector presented to the unit (holds last vector after a scan)
//   busy        scan in progress
//   done        one-cycle completion pulse
//   table_o     bit i = response captured for vector i
// Optional feature (macro SCAN_CHECK_EN):
//   exp_i       expected table, captured at accepted start
//   mismatch    table_o differs from captured expectation (valid from done on)
//   mism_idx    lowest differing index, 0 if none
module f7_scan_ctrl #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   res_i,
    output logic [N_IN-1:0]        vec_o,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_o
`ifdef SCAN_CHECK_EN
    ,
    input  logic [(1<<N_IN)-1:0]   exp_i,
    output logic                   mismatch,
    output logic [N_IN-1:0]        mism_idx
`endif
);

    localparam int unsigned TW = 1 << N_IN;
    localparam int unsigned CW = ($clog2(SETTLE + 1) > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   table_q, table_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef SCAN_CHECK_EN
    logic [TW-1:0]   exp_q, exp_d;
    logic            mismatch_q, mismatch_d;
    logic [N_IN-1:0] mism_idx_q, mism_idx_d;
    logic [N_IN-1:0] first_diff;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                    table_d = '0;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    table_d[idx_q] = res_i;
                    if (idx_q == LAST_IDX) begin
                        // idx stays on the last vector so vec_o holds it
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

`ifdef SCAN_CHECK_EN
    // Result check; evaluated on the final table so it is valid with done
    always_comb begin
        exp_d      = exp_q;
        mismatch_d = mismatch_q;
        mism_idx_d = mism_idx_q;
        first_diff = '0;

        for (int i = int'(TW) - 1; i >= 0; i--) begin
            if (table_d[i] != exp_q[i]) begin
                first_diff = N_IN'(i);
            end
        end

        if (state_q == S_IDLE && start) begin
            exp_d      = exp_i;
            mismatch_d = 1'b0;
            mism_idx_d = '0;
        end else if (state_q == S_RUN && state_d == S_DONE) begin
            mismatch_d = (table_d != exp_q);
            mism_idx_d = first_diff;
        end
    end
`endif

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCAN_CHECK_EN
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            mism_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SCAN_CHECK_EN
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            mism_idx_q <= mism_idx_d;
`endif
        end
    end

    assign vec_o   = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign table_o = table_q;
`ifdef SCAN_CHECK_EN
    assign mismatch = mismatch_q;
    assign mism_idx = mism_idx_q;
`endif

endmodule
